// File: rtl/usart_pkg.sv
// usart_pkg: definitions shared by the USART transmit arbiter and the my_usart
// transmitter.
//   BYTE_W                 - width of one transmitted byte
//   DEFAULT_ACCEPT_TIMEOUT - default number of cycles to wait for the USART
//                            to take a byte after the start pulse
//   state_e                - arbiter sequencing states
package usart_pkg;

  localparam int          BYTE_W                 = 8;
  localparam logic [15:0] DEFAULT_ACCEPT_TIMEOUT = 16'd1000;

  typedef enum logic [1:0] {
    ST_IDLE        = 2'd0,
    ST_LOAD        = 2'd1,
    ST_WAIT_ACCEPT = 2'd2,
    ST_WAIT_DONE   = 2'd3
  } state_e;

endpackage

// File: rtl/usart_tx_arbiter_rr_pick.sv
// rr_pick: combinational round-robin selector.
//   req_i - request vector, one bit per requester
//   ptr_i - index where the search starts (highest priority this cycle)
//   gnt_o - one-hot grant for the first set request at or after ptr_i
//   idx_o - encoded index of gnt_o (0 when nothing is requested)
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [ID_W-1:0]    ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [ID_W-1:0]    idx_o
);

  logic found;
  int   cand;

  // Walk the requesters starting at the pointer with wrap-around; first hit wins.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    cand  = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = int'(ptr_i) + k;
      if (cand >= NUM_REQ) begin
        cand = cand - NUM_REQ;
      end else begin
        cand = cand;
      end
      if (!found && req_i[cand]) begin
        gnt_o[cand] = 1'b1;
        idx_o       = ID_W'(cand);
        found       = 1'b1;
      end else begin
        found = found;
      end
    end
  end

endmodule

// File: rtl/usart_tx_arbiter.sv
// usart_tx_arbiter: shares one my_usart transmitter between NUM_REQ byte
// sources with packet-level round-robin arbitration.
//   clock, reset      - system clock, synchronous active-high reset
//   req_valid/data/last (in)  - per-requester byte offer, last = end of packet
//   req_ready (out)   - one-hot, single-cycle: that requester's byte was taken
//   uart_data/uart_start (out), uart_idle (in) - byte handshake with the USART
//   grant_id/grant_active (out) - current packet owner
//   err_timeout (out) - sticky: the USART never took a started byte
module usart_tx_arbiter
  import usart_pkg::*;
#(
  parameter int          NUM_REQ        = 4,
  parameter int          ID_W           = 2,
  parameter logic [15:0] ACCEPT_TIMEOUT = DEFAULT_ACCEPT_TIMEOUT
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*BYTE_W-1:0] req_data,
  input  logic [NUM_REQ-1:0]        req_last,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [BYTE_W-1:0]         uart_data,
  output logic                      uart_start,
  input  logic                      uart_idle,
  output logic [ID_W-1:0]           grant_id,
  output logic                      grant_active,
  output logic                      err_timeout
);

  state_e              state_q;
  logic [ID_W-1:0]     ptr_q;
  logic [ID_W-1:0]     grant_id_q;
  logic                grant_active_q;
  logic [NUM_REQ-1:0]  req_ready_q;
  logic [BYTE_W-1:0]   uart_data_q;
  logic                uart_start_q;
  logic                last_q;
  logic [15:0]         cnt_q;
  logic                err_q;

  logic [NUM_REQ-1:0]  pick_gnt;
  logic [ID_W-1:0]     pick_idx;
  logic [ID_W-1:0]     sel_id;
  logic                sel_valid;
  logic [BYTE_W-1:0]   sel_byte;
  logic                sel_last;
  logic [NUM_REQ-1:0]  ready_d;
  logic                accept;
  logic [ID_W-1:0]     ptr_d;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr_pick (
    .req_i (req_valid),
    .ptr_i (ptr_q),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx)
  );

  // Selected requester: the packet owner if one exists, else the round-robin pick.
  always_comb begin
    sel_id    = grant_active_q ? grant_id_q : pick_idx;
    sel_valid = req_valid[sel_id];
    sel_byte  = req_data[int'(sel_id)*BYTE_W +: BYTE_W];
    sel_last  = req_last[sel_id];
    ready_d   = grant_active_q ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << grant_id_q) : pick_gnt;
    // Without an owner, sel_valid is only true when the pick found a request.
    accept    = uart_idle && sel_valid;
    if (grant_id_q == ID_W'(NUM_REQ-1)) begin
      ptr_d = '0;
    end else begin
      ptr_d = grant_id_q + ID_W'(1);
    end
  end

  // Byte sequencing FSM with all outputs registered.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      ptr_q          <= '0;
      grant_id_q     <= '0;
      grant_active_q <= 1'b0;
      req_ready_q    <= '0;
      uart_data_q    <= '0;
      uart_start_q   <= 1'b0;
      last_q         <= 1'b0;
      cnt_q          <= 16'd0;
      err_q          <= 1'b0;
    end else begin
      req_ready_q  <= '0;
      uart_start_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          // The grant may be taken and the first byte accepted in the same cycle.
          if (!grant_active_q && (|req_valid)) begin
            grant_active_q <= 1'b1;
            grant_id_q     <= pick_idx;
          end
          if (accept) begin
            uart_data_q <= sel_byte;
            last_q      <= sel_last;
            req_ready_q <= ready_d;
            state_q     <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          uart_start_q <= 1'b1;
          cnt_q        <= 16'd0;
          state_q      <= ST_WAIT_ACCEPT;
        end
        ST_WAIT_ACCEPT: begin
          if (!uart_idle) begin
            state_q <= ST_WAIT_DONE;
          end else if (cnt_q == ACCEPT_TIMEOUT - 16'd1) begin
            // Give up on a stuck transmitter and hand the line to the next source.
            err_q          <= 1'b1;
            grant_active_q <= 1'b0;
            ptr_q          <= ptr_d;
            state_q        <= ST_IDLE;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        ST_WAIT_DONE: begin
          if (uart_idle) begin
            if (last_q) begin
              grant_active_q <= 1'b0;
              ptr_q          <= ptr_d;
            end
            state_q <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign req_ready    = req_ready_q;
  assign uart_data    = uart_data_q;
  assign uart_start   = uart_start_q;
  assign grant_id     = grant_id_q;
  assign grant_active = grant_active_q;
  assign err_timeout  = err_q;

endmodule

// File: tb/tb_usart_tx_arbiter.sv
// tb_usart_tx_arbiter: self-checking bench for usart_tx_arbiter with a
// packet-level reference model (byte queues per requester, an owner and a
// round-robin pointer) and a simple behavioural USART.
module tb_usart_tx_arbiter;
  import usart_pkg::*;

  localparam int          N   = 4;
  localparam int          IDW = 2;
  localparam logic [15:0] AT  = 16'd8;

  logic               clock = 1'b0;
  logic               reset;
  logic [N-1:0]       req_valid;
  logic [N*8-1:0]     req_data;
  logic [N-1:0]       req_last;
  logic [N-1:0]       req_ready;
  logic [7:0]         uart_data;
  logic               uart_start;
  logic               uart_idle;
  logic [IDW-1:0]     grant_id;
  logic               grant_active;
  logic               err_timeout;

  always #5 clock = ~clock;

  usart_tx_arbiter #(
    .NUM_REQ        (N),
    .ID_W           (IDW),
    .ACCEPT_TIMEOUT (AT)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_last     (req_last),
    .req_ready    (req_ready),
    .uart_data    (uart_data),
    .uart_start   (uart_start),
    .uart_idle    (uart_idle),
    .grant_id     (grant_id),
    .grant_active (grant_active),
    .err_timeout  (err_timeout)
  );

  // Behavioural USART: busy for busy_len cycles after a start, or deaf when stuck.
  logic u_idle;
  int   u_busy;
  int   busy_len;
  bit   stuck;
  assign uart_idle = u_idle;

  always @(posedge clock) begin
    if (reset) begin
      u_idle <= 1'b1;
      u_busy <= 0;
    end else if (uart_start && !stuck) begin
      u_idle <= 1'b0;
      u_busy <= busy_len;
    end else if (u_busy > 1) begin
      u_busy <= u_busy - 1;
    end else if (u_busy == 1) begin
      u_busy <= 0;
      u_idle <= 1'b1;
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Requester sources and reference model state.
  logic [8:0] pq [N][$];
  int         hold [N];
  bit         rnd_holds;
  int         m_owner;
  int         m_ptr;
  int         m_cur;
  bit         exp_start;
  logic [7:0] exp_byte;
  int         cyc;
  int         start_cyc;
  logic       err_prev;
  logic [7:0] tx_log [$];
  int         ready_cnt [N];

  function automatic int rr_expect(input int p, input logic [N-1:0] v);
    for (int k = 0; k < N; k++) begin
      if (v[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [31:0] log_at(input int i);
    if (i < tx_log.size()) return {24'd0, tx_log[i]};
    return 32'hFFFF_FFFF;
  endfunction

  function automatic bit all_empty();
    for (int i = 0; i < N; i++) begin
      if (pq[i].size() != 0) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      pq[i].delete();
      hold[i] = 0;
    end
    m_owner   = -1;
    m_ptr     = 0;
    m_cur     = 0;
    exp_start = 1'b0;
  endtask

  task automatic push(input int r, input logic [7:0] b, input logic l);
    pq[r].push_back({l, b});
  endtask

  // Compare DUT outputs of the edge just passed with the packet-level model.
  task automatic monitor();
    int idx;
    if (exp_start) begin
      check("start_pulse", {31'd0, uart_start}, 32'd1);
      check("start_data", {24'd0, uart_data}, {24'd0, exp_byte});
      exp_start = 1'b0;
      start_cyc = cyc;
    end else begin
      check("start_spurious", {31'd0, uart_start}, 32'd0);
    end
    if (uart_start) tx_log.push_back(uart_data);
    if (req_ready != '0) begin
      check("ready_onehot", {31'd0, $onehot(req_ready)}, 32'd1);
      idx = 0;
      for (int k = N - 1; k >= 0; k--) begin
        if (req_ready[k]) idx = k;
      end
      check("ready_owner", idx, (m_owner >= 0) ? m_owner : rr_expect(m_ptr, req_valid));
      check("grant_active_on_ready", {31'd0, grant_active}, 32'd1);
      check("grant_id_on_ready", {30'd0, grant_id}, idx);
      check("ready_has_data", (pq[idx].size() > 0) ? 32'd1 : 32'd0, 32'd1);
      if (pq[idx].size() > 0) begin
        exp_byte = pq[idx][0][7:0];
        if (pq[idx][0][8]) begin
          m_owner = -1;
          m_ptr   = (idx + 1) % N;
        end else begin
          m_owner = idx;
        end
        m_cur = idx;
        void'(pq[idx].pop_front());
        exp_start = 1'b1;
        ready_cnt[idx]++;
      end
    end
    if (err_timeout && !err_prev) begin
      check("timeout_latency", cyc - start_cyc, {16'd0, AT});
      check("timeout_release", {31'd0, grant_active}, 32'd0);
      m_owner = -1;
      m_ptr   = (m_cur + 1) % N;
    end
    err_prev = err_timeout;
  endtask

  task automatic drive();
    bit v;
    for (int i = 0; i < N; i++) begin
      if (hold[i] > 0) begin
        hold[i]--;
      end else if (rnd_holds && pq[i].size() > 0 && $urandom_range(0, 15) == 0) begin
        hold[i] = $urandom_range(1, 6);
      end
      v = (pq[i].size() > 0) && (hold[i] == 0);
      req_valid[i]       = v;
      req_data[8*i +: 8] = v ? pq[i][0][7:0] : 8'($urandom);
      req_last[i]        = v ? pq[i][0][8] : 1'($urandom);
    end
    if (rnd_holds) busy_len = $urandom_range(1, 5);
  endtask

  task automatic step();
    @(negedge clock);
    cyc++;
    monitor();
    drive();
  endtask

  task automatic run(input int budget, input string tag);
    int quiet;
    bit done;
    quiet = 0;
    done  = 1'b0;
    for (int n = 0; n < budget && !done; n++) begin
      step();
      if (all_empty() && !exp_start && u_idle && u_busy == 0 && !uart_start) quiet++;
      else quiet = 0;
      if (quiet >= 6) done = 1'b1;
    end
    check({tag, "_done"}, {31'd0, done}, 32'd1);
  endtask

  task automatic check_log(input string tag, input int n,
                           input logic [31:0] e0, input logic [31:0] e1,
                           input logic [31:0] e2, input logic [31:0] e3);
    logic [31:0] e [4];
    e = '{e0, e1, e2, e3};
    check({tag, "_count"}, tx_log.size(), n);
    for (int i = 0; i < n; i++) check({tag, "_byte"}, log_at(i), e[i]);
  endtask

  initial begin
    int r0;
    int total;
    int len;
    int r;
    reset     = 1'b1;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    stuck     = 1'b0;
    busy_len  = 3;
    rnd_holds = 1'b0;
    cyc       = 0;
    start_cyc = 0;
    err_prev  = 1'b0;
    for (int i = 0; i < N; i++) ready_cnt[i] = 0;
    model_reset();

    repeat (3) @(negedge clock);
    check("rst_req_ready", {28'd0, req_ready}, 32'd0);
    check("rst_uart_data", {24'd0, uart_data}, 32'd0);
    check("rst_uart_start", {31'd0, uart_start}, 32'd0);
    check("rst_grant_id", {30'd0, grant_id}, 32'd0);
    check("rst_grant_active", {31'd0, grant_active}, 32'd0);
    check("rst_err_timeout", {31'd0, err_timeout}, 32'd0);
    reset = 1'b0;

    // Contention from reset: four 1-byte packets, then a second round.
    push(0, 8'h10, 1'b1); push(1, 8'h20, 1'b1); push(2, 8'h30, 1'b1); push(3, 8'h40, 1'b1);
    run(400, "contend1");
    check_log("contend1", 4, 32'h10, 32'h20, 32'h30, 32'h40);
    tx_log.delete();
    push(0, 8'h11, 1'b1); push(1, 8'h21, 1'b1); push(2, 8'h31, 1'b1); push(3, 8'h41, 1'b1);
    run(400, "contend2");
    check_log("contend2", 4, 32'h11, 32'h21, 32'h31, 32'h41);

    // Single requester, single 1-byte packet.
    tx_log.delete();
    r0 = ready_cnt[0];
    push(0, 8'h41, 1'b1);
    run(200, "single");
    check_log("single", 1, 32'h41, 32'h0, 32'h0, 32'h0);
    check("single_ready_pulses", ready_cnt[0] - r0, 32'd1);
    check("single_grant_dropped", {31'd0, grant_active}, 32'd0);

    // Packet lock: req2 must not interleave with req1's packet.
    tx_log.delete();
    push(1, 8'hA1, 1'b0); push(1, 8'hA2, 1'b0); push(1, 8'hA3, 1'b1);
    push(2, 8'hB0, 1'b1);
    run(400, "lock");
    check_log("lock", 4, 32'hA1, 32'hA2, 32'hA3, 32'hB0);

    // Owner stall: req1 goes quiet mid-packet while req3 waits.
    tx_log.delete();
    push(1, 8'h51, 1'b0); push(1, 8'h52, 1'b0); push(1, 8'h53, 1'b1);
    r0 = ready_cnt[1];
    for (int n = 0; n < 60 && ready_cnt[1] == r0; n++) step();
    check("stall_first_accept", ready_cnt[1] - r0, 32'd1);
    step();
    push(3, 8'h5F, 1'b1);
    hold[1] = 22;
    for (int n = 0; n < 20; n++) begin
      step();
      check("stall_grant_id", {30'd0, grant_id}, 32'd1);
      check("stall_grant_active", {31'd0, grant_active}, 32'd1);
      check("stall_no_start", {31'd0, uart_start}, 32'd0);
    end
    run(400, "stall");
    check_log("stall", 4, 32'h51, 32'h52, 32'h53, 32'h5F);

    // Accept timeout: the USART ignores the start pulse.
    tx_log.delete();
    stuck = 1'b1;
    push(0, 8'h55, 1'b1); push(1, 8'h66, 1'b1);
    for (int n = 0; n < 100 && !err_timeout; n++) step();
    stuck = 1'b0;
    check("timeout_flag", {31'd0, err_timeout}, 32'd1);
    run(400, "timeout");
    check_log("timeout", 2, 32'h55, 32'h66, 32'h0, 32'h0);
    check("timeout_sticky", {31'd0, err_timeout}, 32'd1);

    // Reset in WAIT_DONE of a multi-byte packet from req2.
    tx_log.delete();
    busy_len = 6;
    push(2, 8'hC1, 1'b0); push(2, 8'hC2, 1'b1);
    for (int n = 0; n < 60 && u_idle; n++) step();
    check("midrst_busy", {31'd0, u_idle}, 32'd0);
    step();
    step();
    reset = 1'b1;
    model_reset();
    drive();
    step();
    check("midrst_req_ready", {28'd0, req_ready}, 32'd0);
    check("midrst_uart_data", {24'd0, uart_data}, 32'd0);
    check("midrst_uart_start", {31'd0, uart_start}, 32'd0);
    check("midrst_grant_id", {30'd0, grant_id}, 32'd0);
    check("midrst_grant_active", {31'd0, grant_active}, 32'd0);
    check("midrst_err_timeout", {31'd0, err_timeout}, 32'd0);
    reset    = 1'b0;
    busy_len = 3;
    tx_log.delete();
    push(0, 8'hD0, 1'b1); push(1, 8'hD1, 1'b1); push(2, 8'hD2, 1'b1); push(3, 8'hD3, 1'b1);
    run(400, "midrst");
    check_log("midrst", 4, 32'hD0, 32'hD1, 32'hD2, 32'hD3);

    // Randomized packets with random owner and non-owner stalls.
    tx_log.delete();
    rnd_holds = 1'b1;
    total = 0;
    for (int p = 0; p < 40; p++) begin
      r   = $urandom_range(0, N - 1);
      len = $urandom_range(1, 4);
      for (int b = 0; b < len; b++) push(r, 8'($urandom), (b == len - 1) ? 1'b1 : 1'b0);
      total += len;
    end
    run(20000, "random");
    rnd_holds = 1'b0;
    check("random_bytes_sent", tx_log.size(), total);
    check("random_grant_dropped", {31'd0, grant_active}, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/usart_tx_arbiter.md
Name: usart_tx_arbiter

Overview:
- Shares one my_usart transmitter between NUM_REQ byte sources (status reporter, echo path, debug message ROM, ...).
- Round-robin arbitration at packet granularity: once a requester is granted, it keeps the transmitter until it sends a byte flagged last, so packets never interleave.
- Sequences the USART start/idle handshake per byte and flags a stuck transmitter.

Parameters:
- NUM_REQ, 4, number of requesters; legal range 2..8.
- ID_W, 2, width of grant_id; must equal clog2(NUM_REQ).
- ACCEPT_TIMEOUT, 16'd1000, cycles to wait after uart_start for uart_idle to fall before declaring a timeout.

Ports:
- clock  input  1  system clock; all logic on posedge.
- reset  input  1  synchronous, active-high.
- req_valid  input  NUM_REQ  bit i: requester i presents a byte.
- req_data  input  NUM_REQ*8  byte of requester i at bits [8i+7:8i].
- req_last  input  NUM_REQ  bit i: presented byte ends requester i's packet.
- req_ready  output  NUM_REQ  one-hot, single-cycle: requester i's byte is consumed this cycle.
- uart_data  output  8  byte to the USART; held stable from the start pulse until completion.
- uart_start  output  1  single-cycle start pulse to the USART.
- uart_idle  input  1  1 = USART idle and able to accept a byte.
- grant_id  output  ID_W  index of the current owner; valid while grant_active = 1.
- grant_active  output  1  a packet owner exists.
- err_timeout  output  1  sticky; set on accept timeout, cleared only by reset.

Behaviour:
- Reset values: req_ready = 0, uart_data = 0, uart_start = 0, grant_id = 0, grant_active = 0, err_timeout = 0. The round-robin pointer resets to 0. State resets to IDLE.
- Reset mid-transfer aborts immediately. The USART may still finish its current byte; the arbiter does not wait for it.
- States: IDLE, LOAD, WAIT_ACCEPT, WAIT_DONE.
- IDLE:
  - If grant_active = 0 and any req_valid is set, choose the first set bit searching from the pointer upward, with wrap-around.
  - Set grant_id and grant_active = 1.
  - If grant_active = 1, consider only req_valid[grant_id].
  - Proceed only when uart_idle = 1 and the selected req_valid = 1.
  - In that cycle: capture the byte into uart_data, capture the last flag internally, assert req_ready[sel] for exactly that cycle, then go to LOAD.
  - If the owner deasserts valid mid-packet, wait in IDLE while keeping the grant. No other requester may preempt.
- LOAD: assert uart_start for one cycle; load the timeout counter with 0; go to WAIT_ACCEPT.
- WAIT_ACCEPT:
  - When uart_idle = 0, go to WAIT_DONE.
  - Otherwise increment the counter. If it reaches ACCEPT_TIMEOUT-1, set err_timeout, drop grant_active, advance the pointer to grant_id+1 mod NUM_REQ, and go to IDLE.
- WAIT_DONE:
  - When uart_idle = 1, the byte is complete.
  - If the captured last flag = 1: drop grant_active and set the pointer to grant_id+1 mod NUM_REQ.
  - Go to IDLE.
- Per-byte latency:
  - Acceptance (req_ready) falls in the same cycle as the arbitration decision.
  - uart_start follows 1 cycle after req_ready.
  - The minimum gap between successive req_ready pulses is 4 cycles plus the USART busy time.
- Simultaneous events:
  - Valid from several requesters: the pointer decides.
  - A non-owner asserting valid during a packet is ignored.
  - A byte with last = 1 that is also the first byte is a legal 1-byte packet.
- The pointer wraps from NUM_REQ-1 to 0.
- req_data outside the accepted cycle is don't-care.
- No combinational path from inputs to uart_start or uart_data; both are registered.

Decomposition:
- Shared package usart_pkg:
  - state encoding constants ST_IDLE, ST_LOAD, ST_WAIT_ACCEPT, ST_WAIT_DONE;
  - the default timeout constant;
  - the byte width 8, shared with my_usart.
- One sub-module, rr_pick: combinational round-robin selector. Inputs: request vector and pointer. Outputs: one-hot grant and encoded index. The parent instantiates it once.

Test Plan:
- Single requester: req0 sends 0x41 with last = 1; USART model idle after 3 busy cycles -> one uart_start with uart_data = 0x41; req_ready[0] pulses once; grant_active drops afterwards.
- Contention: req0..3 all valid with 1-byte packets 0x10, 0x20, 0x30, 0x40 from reset -> uart bytes in order 0x10, 0x20, 0x30, 0x40; a second round again starts at req0.
- Packet lock: req1 sends 3-byte packet 0xA1, 0xA2, 0xA3 (last on third), while req2 is valid throughout with 0xB0 -> uart sequence 0xA1, 0xA2, 0xA3, 0xB0; no B byte interleaved.
- Owner stall: req1 deasserts valid for 20 cycles between bytes of its packet while req3 is valid -> grant_id stays 1 and no uart_start occurs during the stall.
- Timeout: USART model never drops uart_idle after start, ACCEPT_TIMEOUT = 8 -> err_timeout = 1 eight cycles after the start pulse; grant released; the next requester is served.
- Reset mid-packet: assert reset in WAIT_DONE -> next cycle all outputs are 0, state is IDLE, and arbitration restarts from req0.
